// File: rtl/logs_orbit_sequencer.sv
// Drives the logistic-map iteration stage: latch r/x0, discard WARMUP iterations, then stream SAMPLES orbit points.
// Stalls in EMIT hold x/idx with out_valid high until out_ready; done pulses for one cycle at the end of a run.
module logs_orbit_sequencer #(
  parameter int FRAC    = 4,
  parameter int WARMUP  = 16,
  parameter int SAMPLES = 8,
  parameter int CW      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [FRAC+1:0] r_in,
  input  logic [FRAC-1:0] x0_in,
  output logic [FRAC-1:0] map_x,
  output logic [FRAC+1:0] map_r,
  input  logic [FRAC-1:0] map_next_x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FRAC-1:0] out_x,
  output logic [CW-1:0]   out_idx,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_EMIT, S_DONE} state_t;

  // With WARMUP == 0 the warm-up state is never entered, so its terminal count is irrelevant.
  localparam logic [CW-1:0] WLAST = (WARMUP > 0) ? CW'(WARMUP - 1) : '0;
  localparam logic [CW-1:0] SLAST = CW'(SAMPLES - 1);

  state_t          state;
  logic [FRAC-1:0] x_reg;
  logic [FRAC+1:0] r_reg;
  logic [CW-1:0]   cnt;
  logic            valid_q;
  logic            busy_q;
  logic            done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      x_reg   <= '0;
      r_reg   <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            r_reg  <= r_in;
            x_reg  <= x0_in;
            cnt    <= '0;
            busy_q <= 1'b1;
            if (WARMUP == 0) begin
              state   <= S_EMIT;
              valid_q <= 1'b1;
            end else begin
              state <= S_WARMUP;
            end
          end
        end
        S_WARMUP: begin
          x_reg <= map_next_x;
          if (cnt == WLAST) begin
            cnt     <= '0;
            state   <= S_EMIT;
            valid_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            x_reg <= map_next_x;
            cnt   <= cnt + 1'b1;
            if (cnt == SLAST) begin
              state   <= S_DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          cnt    <= '0;
          state  <= S_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign map_x     = x_reg;
  assign map_r     = r_reg;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_x     = valid_q ? x_reg : '0;
  assign out_idx   = valid_q ? cnt : '0;

endmodule
